// File: rtl/tia_hsync_if.sv
// TIA horizontal sync counter port bundle.
// master = counter side, slave = timing/consumer side.
interface tia_hsync_if;
    logic       rsync;
    logic       hphi1;
    logic       hphi2;
    logic       shb;
    logic       shs;
    logic       rhs;
    logic       rcb;
    logic       rhb;
    logic       lrhb;
    logic       cnt;
    logic       rsynd;
    logic [5:0] hcount;

    modport master (
        input  rsync,
        output hphi1, hphi2,
        output shb, shs, rhs, rcb, rhb, lrhb, cnt,
        output rsynd, hcount
    );

    modport slave (
        output rsync,
        input  hphi1, hphi2,
        input  shb, shs, rhs, rcb, rhb, lrhb, cnt,
        input  rsynd, hcount
    );
endinterface

// File: rtl/tia_hsync_counter.sv
// TIA horizontal sync counter: clk/4 two-phase clocks, 57-state line counter.
// Define TIA_HSYNC_LFSR_EN to hold the line index in the 6-bit XNOR LFSR.
module tia_hsync_counter (
    input  logic        clk,
    input  logic        reset,
    tia_hsync_if.master hs
);

`ifdef TIA_HSYNC_LFSR_EN
    function automatic logic [5:0] lfsr_at(input int k);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < k; i++)
            s = {s[4:0], ~(s[5] ^ s[4])};
        return s;
    endfunction

    localparam logic [5:0] H_SHB  = lfsr_at(0);
    localparam logic [5:0] H_SHS  = lfsr_at(4);
    localparam logic [5:0] H_RHS  = lfsr_at(8);
    localparam logic [5:0] H_RCB  = lfsr_at(12);
    localparam logic [5:0] H_RHB  = lfsr_at(16);
    localparam logic [5:0] H_LRHB = lfsr_at(18);
    localparam logic [5:0] H_CNT  = lfsr_at(36);
    localparam logic [5:0] H_END  = lfsr_at(56);
`else
    localparam logic [5:0] H_SHB  = 6'd0;
    localparam logic [5:0] H_SHS  = 6'd4;
    localparam logic [5:0] H_RHS  = 6'd8;
    localparam logic [5:0] H_RCB  = 6'd12;
    localparam logic [5:0] H_RHB  = 6'd16;
    localparam logic [5:0] H_LRHB = 6'd18;
    localparam logic [5:0] H_CNT  = 6'd36;
`endif

    logic [1:0] p_q;
    logic [5:0] h_q;
    logic [5:0] h_d;
    logic [5:0] h_inc;
    logic       wrap;
    logic       step;
    logic       pend_q;
    logic       hphi1_q;
    logic       hphi2_q;

    assign step = (p_q == 2'd3);

`ifdef TIA_HSYNC_LFSR_EN
    // END and the all-ones lock-up state both fall back to index 0
    assign h_inc = {h_q[4:0], ~(h_q[5] ^ h_q[4])};
    assign wrap  = (h_q == H_END) || (h_q == 6'h3f);
`else
    // 56 wraps to 0; 57..63 are illegal and recover the same way
    assign h_inc = h_q + 6'd1;
    assign wrap  = (h_q >= 6'd56);
`endif

    // Line index only moves on the step edge; a pending RSYNC reloads 0
    always_comb begin
        h_d = h_q;
        if (step) begin
            if (pend_q || wrap)
                h_d = '0;
            else
                h_d = h_inc;
        end
    end

    // Phase, line index, RSYNC pending and registered phase clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q     <= 2'd0;
            h_q     <= '0;
            pend_q  <= 1'b0;
            hphi1_q <= 1'b1;
            hphi2_q <= 1'b0;
        end else begin
            p_q     <= p_q + 2'd1;
            h_q     <= h_d;
            hphi1_q <= (p_q == 2'd3);
            hphi2_q <= (p_q == 2'd1);
            if (step && pend_q)
                pend_q <= 1'b0;
            else if (hs.rsync)
                pend_q <= 1'b1;
        end
    end

    assign hs.hphi1  = hphi1_q;
    assign hs.hphi2  = hphi2_q;
    assign hs.rsynd  = pend_q;
    assign hs.hcount = h_q;

    assign hs.shb  = (h_q == H_SHB);
    assign hs.shs  = (h_q == H_SHS);
    assign hs.rhs  = (h_q == H_RHS);
    assign hs.rcb  = (h_q == H_RCB);
    assign hs.rhb  = (h_q == H_RHB);
    assign hs.lrhb = (h_q == H_LRHB);
    assign hs.cnt  = (h_q == H_CNT);

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Directed bench for tia_hsync_counter: free-run line timing,
// RSYNC reload latencies and reset cancelling a pending RSYNC.
module tb_tia_hsync_counter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tia_hsync_if hs ();

    tia_hsync_counter dut (
        .clk   (clk),
        .reset (reset),
        .hs    (hs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int base = 0;
    int rs_lo = -1;
    int rs_hi = -2;
    logic [63:0] seen;

    function automatic logic [5:0] exp_h(input int k);
`ifdef TIA_HSYNC_LFSR_EN
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < k; i++)
            s = {s[4:0], ~(s[5] ^ s[4])};
        return s;
`else
        return 6'(k);
`endif
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        base = 0;
        rs_lo = -1;
        rs_hi = -2;
    endtask

    task automatic check_now();
        int k;
        int ph;
        k  = ((t - base) % 228) / 4;
        ph = t % 4;
        chk1("hphi1", hs.hphi1, ph == 0);
        chk1("hphi2", hs.hphi2, ph == 2);
        chk1("shb",   hs.shb,   k == 0);
        chk1("shs",   hs.shs,   k == 4);
        chk1("rhs",   hs.rhs,   k == 8);
        chk1("rcb",   hs.rcb,   k == 12);
        chk1("rhb",   hs.rhb,   k == 16);
        chk1("lrhb",  hs.lrhb,  k == 18);
        chk1("cnt",   hs.cnt,   k == 36);
        chk1("rsynd", hs.rsynd, (t >= rs_lo) && (t <= rs_hi));
        chk6("hcount", hs.hcount, exp_h(k));
    endtask

    initial begin
        hs.rsync = 1'b0;

        // reset held 3 clk, then three free-running lines
        do_reset(3);
        chk1("rst_hphi1", hs.hphi1, 1'b1);
        chk1("rst_hphi2", hs.hphi2, 1'b0);
        chk1("rst_shb",   hs.shb,   1'b1);
        chk1("rst_rsynd", hs.rsynd, 1'b0);
        chk6("rst_hcount", hs.hcount, exp_h(0));
        seen = '0;
        for (int i = 0; i < 684; i++) begin
            if (t % 228 == 0)
                seen = '0;
            check_now();
            seen[hs.hcount] = 1'b1;
            if (t % 228 == 227)
                chkn("distinct", $countones(seen), 57);
            step();
        end
        check_now();

        // rsync at t=101 (p=1): rsynd 102..103, line restarts at 104
        do_reset(1);
        while (t < 101) begin
            check_now();
            step();
        end
        check_now();
        hs.rsync = 1'b1;
        step();
        hs.rsync = 1'b0;
        rs_lo = 102;
        rs_hi = 103;
        while (t < 360) begin
            if (t == 104)
                base = 104;
            check_now();
            step();
        end

        // rsync at t=103 (p=3): rsynd 104..107, line restarts at 108
        do_reset(1);
        while (t < 103) begin
            check_now();
            step();
        end
        check_now();
        hs.rsync = 1'b1;
        step();
        hs.rsync = 1'b0;
        rs_lo = 104;
        rs_hi = 107;
        while (t < 360) begin
            if (t == 108)
                base = 108;
            check_now();
            step();
        end

        // rsync at t=101 then reset at t=102: pending cancelled
        do_reset(1);
        while (t < 101) begin
            check_now();
            step();
        end
        check_now();
        hs.rsync = 1'b1;
        step();
        hs.rsync = 1'b0;
        rs_lo = 102;
        rs_hi = 102;
        check_now();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        base = 0;
        rs_lo = -1;
        rs_hi = -2;
        while (t < 240) begin
            check_now();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
